// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames instead.
module uart_rx_fifo #(
   parameter int CLK_DIV     = 16,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          io_axiClk,
   input  logic                          io_asyncResetn,
   input  logic                          io_rxd,
   output logic                          io_rdata_valid,
   input  logic                          io_rdata_ready,
   output logic [7:0]                    io_rdata_payload,
   output logic [$clog2(FIFO_DEPTH):0]   io_count,
   output logic                          io_frameErr,
   output logic                          io_overflow,
   input  logic                          io_overflowClr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(CLK_DIV);
   localparam logic [TW-1:0] T_MID = TW'(CLK_DIV/2 - 1);
   localparam logic [TW-1:0] T_END = TW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [TW-1:0]          timer_q;
   logic [2:0]             bit_idx_q;
   logic [7:0]             shift_q;
   logic                   frame_err_q;
   logic                   overflow_q;
   logic [AW:0]            wr_q, rd_q;
   logic [7:0]             mem_q [FIFO_DEPTH];

   logic rxd_s, par_bad, push, pop, full, empty, wr_en;

   assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
   logic parity_q;
   assign par_bad = ^shift_q ^ parity_q;
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], io_rxd};
      end
   end

   // Frame FSM; the timer free-runs and is cleared on every phase change.
   always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         state_q     <= S_IDLE;
         prev_q      <= 1'b1;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         prev_q      <= rxd_s;
         frame_err_q <= 1'b0;
         timer_q     <= (timer_q == T_END) ? '0 : timer_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               timer_q <= '0;
               if (prev_q && !rxd_s) state_q <= S_START;
            end
            S_START: begin
               if (timer_q == T_MID) begin
                  timer_q   <= '0;
                  bit_idx_q <= '0;
                  state_q   <= rxd_s ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (timer_q == T_END) begin
                  shift_q   <= {rxd_s, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                  if (bit_idx_q == 3'd7) state_q <= S_PARITY;
`else
                  if (bit_idx_q == 3'd7) state_q <= S_STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (timer_q == T_END) begin
                  parity_q <= rxd_s;
                  state_q  <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (timer_q == T_END) begin
                  if (!rxd_s) begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_BREAK;
                  end else begin
                     frame_err_q <= par_bad;
                     state_q     <= S_IDLE;
                  end
               end
            end
            S_BREAK: begin
               timer_q <= '0;
               if (rxd_s) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign push  = (state_q == S_STOP) && (timer_q == T_END) && rxd_s && !par_bad;
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && io_rdata_ready;
   // A pop in the same cycle frees the slot the push lands in.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge io_axiClk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= shift_q;
   end

   always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         wr_q       <= '0;
         rd_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (pop)   rd_q <= rd_q + 1'b1;
         if (push && full && !pop) overflow_q <= 1'b1;
         else if (io_overflowClr)  overflow_q <= 1'b0;
      end
   end

   assign io_rdata_valid   = !empty;
   assign io_rdata_payload = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
   assign io_count         = wr_q - rd_q;
   assign io_frameErr      = frame_err_q;
   assign io_overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo (8N1, CLK_DIV=16).
module tb_uart_rx_fifo;

   logic       clk;
   logic       rst_n;
   logic       rxd;
   logic       ready;
   logic       ovf_clr;
   logic       valid;
   logic [7:0] payload;
   logic [4:0] count;
   logic       frame_err;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;

   uart_rx_fifo #(.CLK_DIV(16), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
      .io_axiClk        (clk),
      .io_asyncResetn   (rst_n),
      .io_rxd           (rxd),
      .io_rdata_valid   (valid),
      .io_rdata_ready   (ready),
      .io_rdata_payload (payload),
      .io_count         (count),
      .io_frameErr      (frame_err),
      .io_overflow      (overflow),
      .io_overflowClr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

   // Frame bit k spans posedges 16k..16k+15 counted from the first edge after the drive;
   // the stop bit is sampled at edge 154, so rdy_edge=154 lines ready up with the push.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_edge);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int c = 0; c < 160; c++) begin
         @(posedge clk); #1;
         rxd = f[c/16];
         if (c == rdy_edge)     ready = 1'b1;
         if (c == rdy_edge + 1) ready = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rxd = 1'b1; ready = 1'b0; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (valid !== 1'b0 || count !== 5'd0 || payload !== 8'h00 || overflow !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: valid=%b count=%0d payload=%h ovf=%b ferr=%b, need 0/0/00/0/0",
                  valid, count, payload, overflow, frame_err);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      idle(100);
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || count !== 5'd0 || fe_cnt !== 0) begin
         errors++;
         $display("FAIL idle_line: valid=%b count=%0d ferr_pulses=%0d, need 0/0/0", valid, count, fe_cnt);
      end
   endtask

   task automatic test_basic;
      logic [7:0] exp [3];
      exp[0] = 8'h55; exp[1] = 8'hA3; exp[2] = 8'h0D;
      for (int i = 0; i < 3; i++) begin
         send_frame(exp[i], 1'b1, -10);
         idle(4);
      end
      @(negedge clk);
      checks++;
      if (count !== 5'd3) begin
         errors++;
         $display("FAIL basic_count: count=%0d, need 3", count);
      end
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (valid !== 1'b1 || payload !== exp[i]) begin
            errors++;
            $display("FAIL basic_drain%0d: valid=%b payload=%h, need 1/%h", i, valid, payload, exp[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (valid !== 1'b0 || count !== 5'd0) begin
         errors++;
         $display("FAIL basic_empty: valid=%b count=%0d, need 0/0", valid, count);
      end
      ready = 1'b0;
   endtask

   task automatic test_glitch;
      int fe0;
      fe0 = fe_cnt;
      @(posedge clk); #1 rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      idle(40);
      @(negedge clk);
      checks++;
      if (count !== 5'd0 || fe_cnt !== fe0) begin
         errors++;
         $display("FAIL glitch_ignored: count=%0d ferr_pulses=%0d, need 0/%0d", count, fe_cnt, fe0);
      end
      send_frame(8'h41, 1'b1, -10);
      idle(4);
      @(negedge clk);
      checks++;
      if (count !== 5'd1 || payload !== 8'h41) begin
         errors++;
         $display("FAIL glitch_next_byte: count=%0d payload=%h, need 1/41", count, payload);
      end
      ready = 1'b1; @(negedge clk); ready = 1'b0;
   endtask

   task automatic test_frame_err;
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'h7E, 1'b0, -10);
      idle(40);
      rxd = 1'b1;
      idle(20);
      @(negedge clk);
      checks++;
      if (fe_cnt - fe0 !== 1 || count !== 5'd0) begin
         errors++;
         $display("FAIL frame_err_once: pulses=%0d count=%0d, need 1/0", fe_cnt - fe0, count);
      end
      send_frame(8'h31, 1'b1, -10);
      idle(4);
      @(negedge clk);
      checks++;
      if (count !== 5'd1 || payload !== 8'h31) begin
         errors++;
         $display("FAIL frame_err_recover: count=%0d payload=%h, need 1/31", count, payload);
      end
      ready = 1'b1; @(negedge clk); ready = 1'b0;
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 17; i++) begin
         send_frame(8'(i), 1'b1, -10);
         idle(2);
      end
      @(negedge clk);
      checks++;
      if (count !== 5'd16 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set: count=%0d ovf=%b, need 16/1", count, overflow);
      end
      ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clr: ovf=%b, need 0", overflow);
      end
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (valid !== 1'b1 || payload !== 8'(i)) begin
            errors++;
            $display("FAIL overflow_drain%0d: valid=%b payload=%h, need 1/%h", i, valid, payload, 8'(i));
         end
         @(negedge clk);
      end
      ready = 1'b0;
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL overflow_lost: valid=%b, need 0 (0x10 dropped)", valid);
      end
   endtask

   task automatic test_full_pop_reset;
      for (int i = 0; i < 16; i++) begin
         send_frame(8'h80 + 8'(i), 1'b1, -10);
         idle(2);
      end
      send_frame(8'h99, 1'b1, 154);
      idle(4);
      @(negedge clk);
      checks++;
      if (count !== 5'd16 || overflow !== 1'b0 || payload !== 8'h81) begin
         errors++;
         $display("FAIL full_push_pop: count=%0d ovf=%b head=%h, need 16/0/81", count, overflow, payload);
      end
      for (int c = 0; c < 70; c++) begin
         @(posedge clk); #1;
         rxd = (c < 16) ? 1'b0 : c[4];
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (count !== 5'd0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: count=%0d valid=%b, need 0/0", count, valid);
      end
      rxd = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(20);
      send_frame(8'h5A, 1'b1, -10);
      idle(4);
      @(negedge clk);
      checks++;
      if (count !== 5'd1 || payload !== 8'h5A || overflow !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_frame: count=%0d payload=%h ovf=%b, need 1/5a/0", count, payload, overflow);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overflow();
      test_full_pop_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver with an output FIFO. It sits directly downstream of the SoC UART transmit pin (io_uart_txd) and deserialises the 8N1 byte stream the core prints. Received bytes are buffered in a FIFO and drained over a valid/ready stream, either by the bench console checker or by a host-side bridge. It also reports framing errors and FIFO overflow.

Parameters:
CLK_DIV, 16, io_axiClk cycles per UART bit; must be at least 4 and even.
FIFO_DEPTH, 16, byte entries; power of 2, minimum 2.
SYNC_STAGES, 2, synchroniser flops on io_rxd; minimum 2.

Ports:
io_axiClk  input  1  sole clock.
io_asyncResetn  input  1  asynchronous assert, active-low reset.
io_rxd  input  1  serial line; idle high; connects to SoC io_uart_txd.
io_rdata_valid  output  1  FIFO non-empty.
io_rdata_ready  input  1  consumer accepts head byte.
io_rdata_payload  output  8  FIFO head byte.
io_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
io_frameErr  output  1  one-cycle pulse when the stop bit is sampled low.
io_overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
io_overflowClr  input  1  clears io_overflow.

Behaviour:
- Reset (any time, including mid-frame): FSM goes to IDLE; FIFO is emptied. Reset values: io_rdata_valid=0, io_count=0, io_frameErr=0, io_overflow=0, io_rdata_payload=0. Synchroniser flops reset to 1.
- rxd_s is io_rxd after SYNC_STAGES flops. All decisions use rxd_s. Input-to-detection latency is SYNC_STAGES cycles.
- Bit timer: counts 0..CLK_DIV-1 and wraps.
- FSM states:
  - IDLE: a falling edge on rxd_s (previous 1, current 0) moves to START and clears the timer.
  - START: at timer==CLK_DIV/2-1 (mid start bit), sample rxd_s.
    - 0: move to DATA with bitIdx=0 and timer cleared.
    - 1: glitch; return to IDLE with nothing pushed.
  - DATA: at each timer==CLK_DIV-1, shift rxd_s into the shift register, LSB first. After bit 7, move to STOP (or PARITY when the optional feature is enabled).
  - STOP: at timer==CLK_DIV-1, sample rxd_s.
    - 1: push the byte and return to IDLE.
    - 0: pulse io_frameErr, discard the byte, move to BREAK.
  - BREAK: wait until rxd_s==1, then go to IDLE. A continuous low line therefore yields exactly one frameErr.
- Push timing: the byte is written in the same cycle the stop bit is sampled. io_rdata_valid rises the next cycle.
- FIFO: synchronous first-word-fall-through. Pointers are clog2(FIFO_DEPTH)+1 bits; full/empty is decided by the MSB compare, and the pointers wrap naturally.
- Pop: when io_rdata_valid && io_rdata_ready; the head advances next cycle.
- Push when full with no pop in the same cycle: the byte is dropped and io_overflow is set. FIFO contents are unchanged.
- Push when full with a pop in the same cycle: the push is accepted and io_count is unchanged. The same holds for simultaneous push and pop at any occupancy.
- Push when empty: no bypass to io_rdata_payload; the byte becomes visible the cycle after it is written.
- io_overflowClr: clears io_overflow. If a drop occurs in the same cycle as the clear, the set wins.
- io_rdata_payload: holds the head entry while valid; don't-care when empty.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame is 8E1. A PARITY state follows DATA and samples one bit at timer==CLK_DIV-1.
  - Data XOR parity != 0: the byte is discarded and io_frameErr pulses at the stop-sample cycle (one pulse, even if the stop bit is also bad).
  - A bad stop bit still leads to BREAK.
- Undefined: no PARITY state; frame is 8N1.

Test Plan:
1. Reset release, line idle high for 100 cycles -> io_rdata_valid=0, io_count=0, io_frameErr never pulses.
2. Send 0x55, 0xA3, 0x0D at CLK_DIV=16 with io_rdata_ready=0 -> io_count=3. Then hold ready=1 -> payloads 0x55, 0xA3, 0x0D in order, each valid for 1 cycle, then valid=0.
3. Low glitch of 4 cycles on io_rxd -> returns to IDLE, io_count stays 0. A following 0x41 is received correctly.
4. Send 0x7E with the stop bit driven low, then hold the line low for 40 cycles -> exactly one io_frameErr pulse, nothing pushed. The next 0x31 after the line returns high is received.
5. With ready=0, send 17 bytes 0x00..0x10 -> io_count=16, io_overflow=1, 0x10 lost. Assert io_overflowClr -> io_overflow=0. Drain -> 0x00..0x0F.
6. FIFO full, ready=1 held while byte 0x99 completes -> push and pop in the same cycle, io_count stays 16, io_overflow=0. Assert io_asyncResetn low mid-frame -> io_count=0 immediately; the next frame after release decodes correctly.
